// File: rtl/fp32_minmax_reduce.sv
// fp32_minmax_reduce
//   Streaming min/max reducer for fp32 packets. Each packet arrives on a
//   valid/ready stream delimited by s_last. One result beat is produced per
//   packet, carrying the minimum, the maximum, the element count and a
//   NaN-seen flag.
//   Ordering rules:
//     - NaN is unordered and never becomes min or max.
//     - +0 and -0 compare equal.
//     - Sign and magnitude decide the order.
//     - On a tie the earlier element is kept, with its bit pattern unchanged.
//   A packet made only of NaNs reports the canonical qNaN 7FC00000.
//
//   Optional feature, enabled by defining FP32_MINMAX_INDEX_EN:
//     Adds m_min_idx and m_max_idx, the 0-based packet positions of the
//     reported min and max. These positions saturate the same way as the
//     element count.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   s_valid    in   input beat valid
//   s_ready    out  input beat can be accepted (low while a result is held)
//   s_data     in   fp32 operand
//   s_last     in   final beat of packet
//   m_valid    out  result valid
//   m_ready    in   downstream accepts result
//   m_min      out  smallest ordered element
//   m_max      out  largest ordered element
//   m_count    out  beats accepted in packet, saturating at 2^CNT_W-1
//   m_unord    out  at least one NaN seen
//   m_min_idx  out  (FP32_MINMAX_INDEX_EN) position of m_min
//   m_max_idx  out  (FP32_MINMAX_INDEX_EN) position of m_max
//
// state    | meaning
// ST_FIRST | no beat of the current packet accepted yet; accumulators clear
// ST_ACCUM | packet in progress
// ST_OUT   | result held on m_*, input stalled until m_ready

module fp32_minmax_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_min,
  output logic [31:0]      m_max,
  output logic [CNT_W-1:0] m_count,
  output logic             m_unord
`ifdef FP32_MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] m_min_idx,
  output logic [CNT_W-1:0] m_max_idx
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_FIRST, ST_ACCUM, ST_OUT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             unord_q, unord_d;
  logic             have_ord_q, have_ord_d;
`ifdef FP32_MINMAX_INDEX_EN
  logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
`endif

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Strict a < b. NaNs and the +0/-0 pair are never less than anything.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (is_nan(a) || is_nan(b) || both_zero) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  // In ST_FIRST the accumulators start from a clean slate. This means a
  // single update path covers both the first beat and every later beat.
  logic             first;
  logic [CNT_W-1:0] count_base;
  logic             unord_base;
  logic             have_base;
  logic             d_nan;

  assign first      = (state_q == ST_FIRST);
  assign count_base = first ? '0 : count_q;
  assign unord_base = first ? 1'b0 : unord_q;
  assign have_base  = first ? 1'b0 : have_ord_q;
  assign d_nan      = is_nan(s_data);

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    max_d      = max_q;
    count_d    = count_q;
    unord_d    = unord_q;
    have_ord_d = have_ord_q;
`ifdef FP32_MINMAX_INDEX_EN
    min_idx_d  = min_idx_q;
    max_idx_d  = max_idx_q;
`endif
    case (state_q)
      ST_FIRST, ST_ACCUM: begin
        if (s_valid) begin
          count_d    = (count_base == '1) ? count_base : count_base + CNT_W'(1);
          unord_d    = unord_base | d_nan;
          have_ord_d = have_base;
          if (!d_nan) begin
            if (!have_base) begin
              min_d      = s_data;
              max_d      = s_data;
              have_ord_d = 1'b1;
`ifdef FP32_MINMAX_INDEX_EN
              min_idx_d  = count_base;
              max_idx_d  = count_base;
`endif
            end else begin
              if (fp_lt(s_data, min_q)) begin
                min_d = s_data;
`ifdef FP32_MINMAX_INDEX_EN
                min_idx_d = count_base;
`endif
              end
              if (fp_lt(max_q, s_data)) begin
                max_d = s_data;
`ifdef FP32_MINMAX_INDEX_EN
                max_idx_d = count_base;
`endif
              end
            end
          end
          if (s_last) begin
            state_d = ST_OUT;
            if (!have_ord_d) begin
              min_d = QNAN;
              max_d = QNAN;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d    = ST_FIRST;
          min_d      = '0;
          max_d      = '0;
          count_d    = '0;
          unord_d    = 1'b0;
          have_ord_d = 1'b0;
`ifdef FP32_MINMAX_INDEX_EN
          min_idx_d  = '0;
          max_idx_d  = '0;
`endif
        end
      end
      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FIRST;
      min_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      unord_q    <= 1'b0;
      have_ord_q <= 1'b0;
`ifdef FP32_MINMAX_INDEX_EN
      min_idx_q  <= '0;
      max_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      max_q      <= max_d;
      count_q    <= count_d;
      unord_q    <= unord_d;
      have_ord_q <= have_ord_d;
`ifdef FP32_MINMAX_INDEX_EN
      min_idx_q  <= min_idx_d;
      max_idx_q  <= max_idx_d;
`endif
    end
  end

  assign s_ready = (state_q != ST_OUT);
  assign m_valid = (state_q == ST_OUT);
  assign m_min   = min_q;
  assign m_max   = max_q;
  assign m_count = count_q;
  assign m_unord = unord_q;
`ifdef FP32_MINMAX_INDEX_EN
  assign m_min_idx = min_idx_q;
  assign m_max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_fp32_minmax_reduce.sv
// Bench for fp32_minmax_reduce. Two instances, one with CNT_W=16 and one
// with CNT_W=2, are driven by the same stream. Their results are compared
// against an order-key reference model.
module tb_fp32_minmax_reduce;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_last, m_ready;
  logic [31:0] s_data;

  logic        s_ready, m_valid, m_unord;
  logic [31:0] m_min, m_max;
  logic [15:0] m_count;
  logic        s_ready2, m_valid2, m_unord2;
  logic [31:0] m_min2, m_max2;
  logic [1:0]  m_count2;
`ifdef FP32_MINMAX_INDEX_EN
  logic [15:0] m_min_idx, m_max_idx;
  logic [1:0]  m_min_idx2, m_max_idx2;
`endif

  always #5 clk = ~clk;

  fp32_minmax_reduce #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_min(m_min), .m_max(m_max), .m_count(m_count), .m_unord(m_unord)
`ifdef FP32_MINMAX_INDEX_EN
    , .m_min_idx(m_min_idx), .m_max_idx(m_max_idx)
`endif
  );

  fp32_minmax_reduce #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
    .m_min(m_min2), .m_max(m_max2), .m_count(m_count2), .m_unord(m_unord2)
`ifdef FP32_MINMAX_INDEX_EN
    , .m_min_idx(m_min_idx2), .m_max_idx(m_max_idx2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: map each ordered value to a signed key (sign applied to the
  // 31-bit magnitude, so +0 and -0 share key 0) and scan for strict extremes.
  logic [31:0] exp_min, exp_max;
  logic        exp_unord;
  int          exp_cnt, exp_min_pos, exp_max_pos;

  function automatic longint fkey(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model(input logic [31:0] pkt[$]);
    bit have;
    have = 0;
    exp_min = QNAN; exp_max = QNAN; exp_unord = 0;
    exp_min_pos = 0; exp_max_pos = 0;
    exp_cnt = pkt.size();
    foreach (pkt[i]) begin
      if (pkt[i][30:23] == 8'hFF && pkt[i][22:0] != 0) exp_unord = 1;
      else if (!have) begin
        have = 1; exp_min = pkt[i]; exp_max = pkt[i];
        exp_min_pos = i; exp_max_pos = i;
      end else begin
        if (fkey(pkt[i]) < fkey(exp_min)) begin exp_min = pkt[i]; exp_min_pos = i; end
        if (fkey(pkt[i]) > fkey(exp_max)) begin exp_max = pkt[i]; exp_max_pos = i; end
      end
    end
  endtask

  task automatic check_results();
    check("min",    m_min,    exp_min);
    check("max",    m_max,    exp_max);
    check("count",  m_count,  sat(exp_cnt, 65535));
    check("unord",  m_unord,  exp_unord);
    check("min_s",  m_min2,   exp_min);
    check("max_s",  m_max2,   exp_max);
    check("count_s", m_count2, sat(exp_cnt, 3));
    check("unord_s", m_unord2, exp_unord);
`ifdef FP32_MINMAX_INDEX_EN
    check("min_idx",   m_min_idx,  exp_min_pos);
    check("max_idx",   m_max_idx,  exp_max_pos);
    check("min_idx_s", m_min_idx2, sat(exp_min_pos, 3));
    check("max_idx_s", m_max_idx2, sat(exp_max_pos, 3));
`endif
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled there too.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int gap, w;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      s_valid = 0; s_last = 1'($urandom_range(0, 1)); s_data = $urandom;
      @(posedge clk); #1;
    end
    s_valid = 1; s_data = d; s_last = last;
    w = 0;
    while (!s_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic run_packet(input logic [31:0] pkt[$]);
    int hold;
    model(pkt);
    foreach (pkt[i]) send_beat(pkt[i], (i == pkt.size() - 1));
    check("m_valid_lat", m_valid, 1);
    check("m_valid_lat_s", m_valid2, 1);
    check("s_ready_out", s_ready, 0);
    check_results();
    hold = $urandom_range(0, 5);
    m_ready = 0;
    repeat (hold) begin
      s_valid = 1; s_last = 1; s_data = $urandom;
      @(posedge clk); #1;
      check("hold_s_ready", s_ready, 0);
      check("hold_m_valid", m_valid, 1);
      check_results();
    end
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0; s_valid = 0; s_last = 0;
    check("m_valid_clr", m_valid, 0);
    check("count_clr", m_count, 0);
    check("s_ready_first", s_ready, 1);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] tbl [4];
    logic s;
    tbl[0] = 32'h3F80_0000; tbl[1] = 32'h4000_0000;
    tbl[2] = 32'h4060_0000; tbl[3] = 32'h0000_0003;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
      1: return {s, 31'd0};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'h00, 23'($urandom_range(1, 23'h7F_FFFF))};
      4, 5: return {s, tbl[$urandom_range(0, 3)][30:0]};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] q[$];
    rst_n = 0; s_valid = 0; s_last = 0; s_data = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_min", m_min, 0);
    check("rst_max", m_max, 0);
    check("rst_count", m_count, 0);
    check("rst_unord", m_unord, 0);
    check("rst_s_ready", s_ready, 1);
    rst_n = 1;

    q = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000}; run_packet(q);
    q = '{32'h8000_0000, 32'h0000_0000}; run_packet(q);
    q = '{32'h7F80_0000, 32'hFF80_0000}; run_packet(q);
    q = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001}; run_packet(q);
    q = '{32'h7FC0_0001}; run_packet(q);
    q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
          32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000}; run_packet(q);

    // Reset in the middle of a packet discards the partial result.
    send_beat(32'hC2C8_0000, 0);
    send_beat(32'h7FC0_0001, 0);
    rst_n = 0;
    @(posedge clk); #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_min", m_min, 0);
    check("mid_rst_max", m_max, 0);
    check("mid_rst_count", m_count, 0);
    check("mid_rst_unord", m_unord, 0);
    rst_n = 1;
    q = '{32'h4000_0000}; run_packet(q);

    for (int p = 0; p < 40; p++) begin
      int len;
      len = (p % 10 == 9) ? $urandom_range(10, 20) : $urandom_range(1, 6);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(rand_fp());
      run_packet(q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_minmax_reduce.md
Name: fp32_minmax_reduce

Overview:
- Streaming reducer. Accepts a packet of fp32 values over a valid/ready input stream, delimited by s_last.
- Emits one result beat per packet: minimum, maximum, element count and an unordered (NaN-seen) flag.
- Ordering semantics match the team's fp32 comparator: NaN is unordered, +0 == -0, and sign and magnitude decide order.
- Sits downstream of fp32 datapath units; used for statistics and range checks.

Parameters:
- CNT_W, 16, width of element counter m_count.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- s_valid, input, 1, input beat valid.
- s_ready, output, 1, block can accept an input beat.
- s_data, input, 32, fp32 operand.
- s_last, input, 1, final beat of packet.
- m_valid, output, 1, result valid.
- m_ready, input, 1, downstream accepts result.
- m_min, output, 32, smallest ordered element of packet.
- m_max, output, 32, largest ordered element of packet.
- m_count, output, CNT_W, number of beats accepted in packet, NaNs included.
- m_unord, output, 1, at least one NaN in packet.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: m_valid=0, m_min=0, m_max=0, m_count=0, m_unord=0. State=FIRST; internal have_ord=0.
- Reset mid-packet discards partial results. Reset during OUT drops the pending result.
- States and transitions:
  - FIRST: no ordered element held yet. On accept: count=1, unord=isnan(d). If d is not NaN, min=max=d and have_ord=1. Go to OUT if s_last, else ACCUM.
  - ACCUM: on accept, count increments. If d is NaN, set unord and leave min/max untouched. Else if have_ord=0, min=max=d and have_ord=1. Else compare d against min and max, using lt/gt below. Go to OUT if s_last.
  - OUT: m_valid=1, s_ready=0. On m_valid&&m_ready, clear the accumulators and go to FIRST.
- s_ready=1 in FIRST and ACCUM; 0 in OUT.
- Accept happens on s_valid && s_ready.
- Latency: m_valid asserts the cycle after the s_last beat is accepted.
- Throughput: one result-hold bubble per packet, minimum 1 cycle.
- Outputs are stable while m_valid=1 && m_ready=0.
- Compare rules:
  - a<b when both are ordered, they are not both zero, and: signs differ with a negative; or both positive with |a|<|b|; or both negative with |a|>|b|.
  - Magnitude is compared as {exp,mant} unsigned.
  - Update min only when d<min strictly, and max only when d>max strictly. On ties (including +0 vs -0) the earlier element is kept, bit pattern unchanged.
- Infinities are ordinary ordered values.
- Denormals are compared by raw bits; no flush.
- All-NaN packet: m_min=m_max=32'h7FC00000 (canonical qNaN), m_unord=1.
- Single-beat packet (s_last on first beat) is legal.
- Counter saturates at 2^CNT_W-1 and does not wrap; reduction continues.
- s_last with s_valid=0 is ignored.
- s_data and s_last are sampled only on accept.

Optional Feature:
- Macro: FP32_MINMAX_INDEX_EN.
- Defined:
  - Adds ports m_min_idx (output, CNT_W) and m_max_idx (output, CNT_W). Each is the 0-based position within the packet of the element reported in m_min / m_max.
  - Ties keep the earlier index. Reset value is 0.
  - All-NaN packet reports index 0 for both.
  - Index capture uses the pre-increment count, which saturates as well.
- Undefined: ports absent, no index registers; all other behaviour identical.

Test Plan:
- Packet {3F800000 (1.0), C0000000 (-2.0), 40600000 (3.5)}, last on 3rd, m_ready=1 -> next cycle m_valid=1, m_min=C0000000, m_max=40600000, m_count=3, m_unord=0; with INDEX_EN min_idx=1, max_idx=2.
- Packet {80000000 (-0), 00000000 (+0)} -> m_min=m_max=80000000 (tie keeps first), count=2; then packet {7F800000 (+inf), FF800000 (-inf)} -> min=FF800000, max=7F800000.
- Packet {7FC00001, 3F800000, 7FC00001} -> m_min=m_max=3F800000, count=3, m_unord=1; packet {7FC00001} alone -> min=max=7FC00000, unord=1, count=1.
- Hold m_ready=0 for 5 cycles after result, with s_valid=1 driven -> s_ready=0 throughout, outputs stable, no input accepted; on m_ready=1 the handshake completes and FIRST accepts a new beat next cycle.
- Assert rst_n=0 for 1 cycle after 2 beats of a packet -> all outputs 0, m_valid=0. Next packet {40000000} last -> min=max=40000000, count=1, no residue from the aborted packet.
- CNT_W=2, 6-beat packet of increasing values 3F800000..40C00000 -> m_count=3 (saturated), m_min=3F800000, m_max=40C00000.
